// File: rtl/mul_fu_ctrl.sv
// mul_fu_ctrl: issue-side controller for the M-extension multiply unit.
// Accepts one multiply op at a time, drives an external multiplier with a
// start/done handshake, and parks the selected 32-bit result in a one-entry
// output buffer that is broadcast on the CDB until granted.
module mul_fu_ctrl #(
    parameter int ROB_IDX_W = 5,
    parameter int PHYS_W    = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,

    input  logic                 iss_valid,
    output logic                 iss_ready,
    input  logic [2:0]           iss_funct3,
    input  logic [31:0]          iss_rs1_v,
    input  logic [31:0]          iss_rs2_v,
    input  logic [ROB_IDX_W-1:0] iss_rob_idx,
    input  logic [PHYS_W-1:0]    iss_pd,

    output logic                 mul_start,
    output logic [1:0]           mul_type,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_b,
    input  logic                 mul_done,
    input  logic [63:0]          mul_p,

    output logic                 cdb_valid,
    output logic [31:0]          cdb_value,
    output logic [ROB_IDX_W-1:0] cdb_rob_idx,
    output logic [PHYS_W-1:0]    cdb_pd,
    input  logic                 cdb_grant
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Multiplier operand signedness: 01 signed x signed, 10 signed x unsigned,
    // 11 unsigned x unsigned. MUL only needs the low word, which is the same
    // for every signedness, so it uses the unsigned form.
    function automatic logic [1:0] funct3_to_type(input logic [1:0] f);
        logic [1:0] t;
        case (f)
            2'b00:   t = 2'b11;
            2'b01:   t = 2'b01;
            2'b10:   t = 2'b10;
            default: t = 2'b11;
        endcase
        return t;
    endfunction

    // Control state (reset)
    state_t state_q, state_d;
    logic   squashed_q, squashed_d;
    logic   out_valid_q, out_valid_d;

    // Latched op and output buffer payload (no reset)
    logic [1:0]           op_funct3_q, op_funct3_d;
    logic [31:0]          op_a_q, op_a_d;
    logic [31:0]          op_b_q, op_b_d;
    logic [ROB_IDX_W-1:0] op_rob_q, op_rob_d;
    logic [PHYS_W-1:0]    op_pd_q, op_pd_d;
    logic [31:0]          out_value_q, out_value_d;
    logic [ROB_IDX_W-1:0] out_rob_q, out_rob_d;
    logic [PHYS_W-1:0]    out_pd_q, out_pd_d;

    logic        accept;
    logic        capture;
    logic [31:0] result;

    // funct3[2] only distinguishes the divide group, which never reaches this unit.
    logic unused_funct3_msb;
    assign unused_funct3_msb = iss_funct3[2];

    assign iss_ready   = (state_q == S_IDLE) & ~flush & ~rst;
    assign accept      = iss_valid & iss_ready;
    assign result      = (op_funct3_q == 2'b00) ? mul_p[31:0] : mul_p[63:32];

    // Outputs decode registered state only; rst gates them so they are quiet
    // during the very first reset cycle, before the state flops have cleared.
    assign mul_start   = (state_q == S_BUSY) & ~rst;
    assign mul_type    = funct3_to_type(op_funct3_q);
    assign mul_a       = op_a_q;
    assign mul_b       = op_b_q;
    assign cdb_valid   = out_valid_q & ~rst;
    assign cdb_value   = out_value_q;
    assign cdb_rob_idx = out_rob_q;
    assign cdb_pd      = out_pd_q;

    // Next-state logic for the op FSM, the squash flag and the output buffer.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        squashed_d  = squashed_q;
        out_valid_d = out_valid_q;
        op_funct3_d = op_funct3_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_rob_d    = op_rob_q;
        op_pd_d     = op_pd_q;
        out_value_d = out_value_q;
        out_rob_d   = out_rob_q;
        out_pd_d    = out_pd_q;
        capture     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_funct3_d = iss_funct3[1:0];
                    op_a_d      = iss_rs1_v;
                    op_b_d      = iss_rs2_v;
                    op_rob_d    = iss_rob_idx;
                    op_pd_d     = iss_pd;
                    squashed_d  = 1'b0;
                    state_d     = S_BUSY;
                end
            end
            S_BUSY: begin
                if (mul_done) begin
                    if (squashed_q || flush) begin
                        // Squashed op: finish the handshake, drop the result.
                        squashed_d = 1'b0;
                        state_d    = S_DRAIN;
                    end else if (!out_valid_q || cdb_grant) begin
                        // Buffer empty, or its entry leaves on this same edge.
                        capture = 1'b1;
                        state_d = S_DRAIN;
                    end
                    // Otherwise hold start/done until the buffer frees up.
                end else if (flush) begin
                    squashed_d = 1'b1;
                end
            end
            S_DRAIN: begin
                // One cycle with start low lets the multiplier return to idle.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (out_valid_q && cdb_grant) begin
            out_valid_d = 1'b0;
        end
        if (capture) begin
            out_valid_d = 1'b1;
            out_value_d = result;
            out_rob_d   = op_rob_q;
            out_pd_d    = op_pd_q;
        end
        if (flush) begin
            out_valid_d = 1'b0;
        end
    end

    // Control flops with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= S_IDLE;
            squashed_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            squashed_q  <= squashed_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Payload flops; always qualified by a valid/state bit, so left unreset.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers carry no reset; nothing reads them until a
        // reset-cleared control bit says they hold a live value.
        op_funct3_q <= op_funct3_d;
        op_a_q      <= op_a_d;
        op_b_q      <= op_b_d;
        op_rob_q    <= op_rob_d;
        op_pd_q     <= op_pd_d;
        out_value_q <= out_value_d;
        out_rob_q   <= out_rob_d;
        out_pd_q    <= out_pd_d;
    end

endmodule

// File: tb/tb_mul_fu_ctrl.sv
// tb_mul_fu_ctrl: directed plus randomized bench for mul_fu_ctrl, with a
// behavioural multiplier and a queue-based reference of expected broadcasts.
module tb_mul_fu_ctrl;

    localparam int ROB_IDX_W = 5;
    localparam int PHYS_W    = 6;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic                 iss_valid;
    logic                 iss_ready;
    logic [2:0]           iss_funct3;
    logic [31:0]          iss_rs1_v;
    logic [31:0]          iss_rs2_v;
    logic [ROB_IDX_W-1:0] iss_rob_idx;
    logic [PHYS_W-1:0]    iss_pd;
    logic                 mul_start;
    logic [1:0]           mul_type;
    logic [31:0]          mul_a;
    logic [31:0]          mul_b;
    logic                 mul_done;
    logic [63:0]          mul_p;
    logic                 cdb_valid;
    logic [31:0]          cdb_value;
    logic [ROB_IDX_W-1:0] cdb_rob_idx;
    logic [PHYS_W-1:0]    cdb_pd;
    logic                 cdb_grant;

    mul_fu_ctrl #(.ROB_IDX_W(ROB_IDX_W), .PHYS_W(PHYS_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_funct3(iss_funct3), .iss_rs1_v(iss_rs1_v), .iss_rs2_v(iss_rs2_v),
        .iss_rob_idx(iss_rob_idx), .iss_pd(iss_pd),
        .mul_start(mul_start), .mul_type(mul_type), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_p(mul_p),
        .cdb_valid(cdb_valid), .cdb_value(cdb_value), .cdb_rob_idx(cdb_rob_idx),
        .cdb_pd(cdb_pd), .cdb_grant(cdb_grant)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_bcast  = 0;
    bit grant_rand = 1'b0;
    bit flush_rand = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        else n_pass++;
    endtask

    // ---------------- behavioural multiplier ----------------
    // Done after mul_lat cycles of start (0 if an operand is zero), then held
    // while start stays high; idles whenever start drops.
    int unsigned mul_lat = 3;
    int unsigned lat_q   = 3;
    int unsigned busy_cnt = 0;

    always @(posedge clk) begin
        if (!mul_start) begin
            busy_cnt <= 0;
            lat_q    <= mul_lat;
        end else if (busy_cnt < 1000) begin
            busy_cnt <= busy_cnt + 1;
        end
    end

    function automatic logic [63:0] model_product(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa, xb;
        xa = (t == 2'b01 || t == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
        xb = (t == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
        return (t == 2'b00) ? 64'h0 : xa * xb;
    endfunction

    always_comb begin
        int unsigned eff;
        eff      = (mul_a == 32'h0 || mul_b == 32'h0) ? 0 : lat_q;
        mul_done = mul_start && (busy_cnt >= eff);
        mul_p    = mul_done ? model_product(mul_type, mul_a, mul_b) : 64'hDEAD_BEEF_DEAD_BEEF;
    end

    // ---------------- reference model ----------------
    // RISC-V result of an M-extension multiply, from funct3 semantics.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        logic [31:0]     lo;
        logic [31:0]     r;
        case (f3[1:0])
            2'b00: begin lo = a * b; r = lo; end
            2'b01: begin sa = longint'($signed(a)); sb = longint'($signed(b)); sp = sa * sb; r = sp[63:32]; end
            2'b10: begin sa = longint'($signed(a)); sb = longint'({32'h0, b}); sp = sa * sb; r = sp[63:32]; end
            default: begin ua = {32'h0, a}; ub = {32'h0, b}; up = ua * ub; r = up[63:32]; end
        endcase
        return r;
    endfunction

    function automatic logic [1:0] spec_type(input logic [2:0] f3);
        logic [1:0] t;
        case (f3[1:0])
            2'b00: t = 2'b11;   // MUL
            2'b01: t = 2'b01;   // MULH
            2'b10: t = 2'b10;   // MULHSU
            default: t = 2'b11; // MULHU
        endcase
        return t;
    endfunction

    typedef struct packed {
        logic [31:0]          value;
        logic [ROB_IDX_W-1:0] rob;
        logic [PHYS_W-1:0]    pd;
    } bcast_t;

    bcast_t      exp_q[$];
    logic [31:0] cur_a, cur_b;
    logic [2:0]  cur_f3;

    // Compare process: every accepted, unflushed op must be broadcast once,
    // in order, with the payload stable until granted.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_mul_start", mul_start, 0);
            check("rst_cdb_valid", cdb_valid, 0);
            check("rst_iss_ready", iss_ready, 0);
            exp_q.delete();
        end else begin
            if (cdb_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_cdb_valid", cdb_valid, 0);
                end else begin
                    check("cdb_value", cdb_value, exp_q[0].value);
                    check("cdb_rob_idx", cdb_rob_idx, exp_q[0].rob);
                    check("cdb_pd", cdb_pd, exp_q[0].pd);
                    if (cdb_grant) void'(exp_q.pop_front());
                end
                if (cdb_grant) n_bcast++;
            end
            if (mul_start) begin
                check("mul_a", mul_a, cur_a);
                check("mul_b", mul_b, cur_b);
                check("mul_type", mul_type, spec_type(cur_f3));
                check("busy_iss_ready", iss_ready, 0);
            end
            if (flush) begin
                check("flush_iss_ready", iss_ready, 0);
                exp_q.delete();
            end
            if (iss_valid && iss_ready) begin
                exp_q.push_back('{value: ref_result(iss_funct3, iss_rs1_v, iss_rs2_v),
                                  rob: iss_rob_idx, pd: iss_pd});
                cur_a  = iss_rs1_v;
                cur_b  = iss_rs2_v;
                cur_f3 = iss_funct3;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        if (grant_rand) cdb_grant = ($urandom_range(0, 1) == 1);
        if (flush_rand) flush = ($urandom_range(0, 15) == 0);
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [ROB_IDX_W-1:0] rob, input logic [PHYS_W-1:0] pd,
                         input int unsigned lat, output int acc);
        bit got;
        got     = 1'b0;
        acc     = -1;
        mul_lat = lat;
        iss_funct3  = f3;
        iss_rs1_v   = a;
        iss_rs2_v   = b;
        iss_rob_idx = rob;
        iss_pd      = pd;
        iss_valid   = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (iss_ready) begin
                got = 1'b1;
                acc = cyc;
                break;
            end
            step();
        end
        if (got) step();
        iss_valid = 1'b0;
        if (!got) check("issue_timeout", 0, 1);
    endtask

    task automatic wait_valid(input int bound, output logic [31:0] v, output logic [ROB_IDX_W-1:0] r,
                              output logic [PHYS_W-1:0] p, output int c);
        bit got;
        got = 1'b0;
        v = '0; r = '0; p = '0; c = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (cdb_valid) begin
                got = 1'b1;
                v = cdb_value;
                r = cdb_rob_idx;
                p = cdb_pd;
                c = cyc;
                break;
            end
            step();
        end
        if (!got) check("wait_valid_timeout", 0, 1);
        step();
    endtask

    // One directed MUL-family op with full grant; returns value and latency.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int unsigned lat, output logic [31:0] v, output int latency);
        int acc, c;
        logic [ROB_IDX_W-1:0] r;
        logic [PHYS_W-1:0]    p;
        issue(f3, a, b, 5'd4, 6'd12, lat, acc);
        wait_valid(30, v, r, p, c);
        latency = c - acc;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int acc, acc2, c, lat, rdy, n_seen, b0;
        logic [31:0]          v;
        logic [ROB_IDX_W-1:0] r;
        logic [PHYS_W-1:0]    p;

        rst = 1'b1; flush = 1'b0; iss_valid = 1'b0; iss_funct3 = '0;
        iss_rs1_v = '0; iss_rs2_v = '0; iss_rob_idx = '0; iss_pd = '0;
        cdb_grant = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("reset_iss_ready", iss_ready, 0);
        check("reset_mul_start", mul_start, 0);
        check("reset_cdb_valid", cdb_valid, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_iss_ready", iss_ready, 1);
        step();

        // MUL 7*6 -> 0x2A, multiplier done 4 cycles after accept, CDB one later.
        issue(3'b000, 32'd7, 32'd6, 5'd3, 6'd9, 3, acc);
        wait_valid(30, v, r, p, c);
        check("mul7x6_value", v, 32'h0000002A);
        check("mul7x6_rob", r, 3);
        check("mul7x6_pd", p, 9);
        check("mul7x6_latency", c - acc, 5);
        @(negedge clk);
        check("mul7x6_single_pulse", cdb_valid, 0);
        step();

        // Signedness corners.
        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, v, lat);
        check("mulh_m1_m1", v, 32'h00000000);
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, v, lat);
        check("mulhu_max_max", v, 32'hFFFFFFFE);
        run_op(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, v, lat);
        check("mul_m1_m1", v, 32'h00000001);
        run_op(3'b010, 32'hFFFFFFFE, 32'd3, 3, v, lat);
        check("mulhsu_m2_3", v, 32'hFFFFFFFF);
        run_op(3'b110, 32'hFFFFFFFE, 32'd3, 3, v, lat);
        check("funct3_bit2_ignored", v, 32'hFFFFFFFF);
        run_op(3'b000, 32'd0, 32'd5, 4, v, lat);
        check("mul_zero_value", v, 32'h00000000);
        check("mul_zero_early_latency", lat, 2);

        // Back-pressure: two MULs with grant held low.
        cdb_grant = 1'b0;
        issue(3'b000, 32'd5, 32'd5, 5'd1, 6'd2, 3, acc);
        issue(3'b000, 32'd6, 32'd6, 5'd2, 6'd3, 3, acc2);
        check("bp_second_accept_gap", acc2 - acc, 6);
        repeat (4) step();
        @(negedge clk);
        check("bp_hold_cdb_valid", cdb_valid, 1);
        check("bp_hold_value", cdb_value, 32'h19);
        check("bp_hold_mul_start", mul_start, 1);
        check("bp_hold_mul_done", mul_done, 1);
        step();
        cdb_grant = 1'b1;
        @(negedge clk);
        check("bp_grant_value", cdb_value, 32'h19);
        step();
        @(negedge clk);
        check("bp_second_valid", cdb_valid, 1);
        check("bp_second_value", cdb_value, 32'h24);
        check("bp_second_rob", cdb_rob_idx, 2);
        step();
        @(negedge clk);
        check("bp_drained", cdb_valid, 0);
        step();

        // Flush in the second BUSY cycle.
        issue(3'b000, 32'd3, 32'd3, 5'd5, 6'd5, 3, acc);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_seen = 0;
        rdy = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cdb_valid) n_seen++;
            if (iss_ready) begin
                rdy = cyc;
                break;
            end
            step();
        end
        step();
        check("flush_no_cdb", n_seen, 0);
        check("flush_ready_after_drain", rdy - acc, 6);
        run_op(3'b000, 32'd2, 32'd2, 3, v, lat);
        check("after_flush_value", v, 32'h4);

        // Reset mid-BUSY.
        issue(3'b000, 32'd7, 32'd7, 5'd7, 6'd7, 5, acc);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_mul_start", mul_start, 0);
        check("midrst_cdb_valid", cdb_valid, 0);
        check("midrst_iss_ready", iss_ready, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_after", iss_ready, 1);
        step();
        b0 = n_bcast;
        issue(3'b000, 32'd9, 32'd9, 5'd8, 6'd8, 3, acc);
        wait_valid(30, v, r, p, c);
        check("midrst_next_value", v, 32'h51);
        repeat (10) step();
        check("midrst_one_broadcast", n_bcast - b0, 1);

        // Randomized traffic with random grant and occasional flush.
        grant_rand = 1'b1;
        flush_rand = 1'b1;
        for (int k = 0; k < 150; k++) begin
            logic [31:0] ra, rb;
            int unsigned m;
            m  = $urandom_range(0, 7);
            ra = (m == 0) ? 32'h0 : (m == 1) ? 32'hFFFFFFFF : (m == 2) ? 32'h80000000 : $urandom;
            m  = $urandom_range(0, 7);
            rb = (m == 0) ? 32'h0 : (m == 1) ? 32'hFFFFFFFF : (m == 2) ? 32'h80000000 : $urandom;
            issue(3'($urandom_range(0, 7)), ra, rb, 5'($urandom), 6'($urandom),
                  $urandom_range(0, 5), acc);
            repeat ($urandom_range(0, 3)) step();
        end
        grant_rand = 1'b0;
        flush_rand = 1'b0;
        flush = 1'b0;
        cdb_grant = 1'b1;
        repeat (20) step();
        @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_cdb_idle", cdb_valid, 0);
        check("final_iss_ready", iss_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mul_fu_ctrl.md
MUL_FU_CTRL -- requirements
Module: mul_fu_ctrl

Interface
REQ-001 SHALL have parameter ROB_IDX_W, default 5, ROB index width.
REQ-002 SHALL have parameter PHYS_W, default 6, physical register index width.
REQ-003 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  in  1  pipeline flush (mispredict); squashes held and in-flight ops.
REQ-006 SHALL have ports iss_valid in 1, iss_ready out 1  issue handshake.
REQ-007 SHALL have ports iss_funct3 in 3, iss_rs1_v in 32, iss_rs2_v in 32, iss_rob_idx in ROB_IDX_W, iss_pd in PHYS_W  issued M-extension multiply op.
REQ-008 SHALL have ports mul_start out 1, mul_type out 2, mul_a out 32, mul_b out 32  multiplier request.
REQ-009 SHALL have ports mul_done in 1, mul_p in 64  multiplier response.
REQ-010 SHALL have ports cdb_valid out 1, cdb_value out 32, cdb_rob_idx out ROB_IDX_W, cdb_pd out PHYS_W, cdb_grant in 1  result broadcast.

Function
REQ-011 SHALL implement states IDLE, BUSY, DRAIN, plus an independent one-entry output buffer (out_valid).
REQ-012 SHALL drive iss_ready = (state==IDLE) & !flush & !rst; accept an op on iss_valid & iss_ready and latch funct3, rs1, rs2, rob_idx, pd; IDLE->BUSY.
REQ-013 SHALL drive mul_start=1 only in BUSY, with mul_a/mul_b/mul_type held constant from the cycle after accept until leaving BUSY.
REQ-014 SHALL map funct3: 000 MUL -> mul_type 11; 001 MULH -> 01; 010 MULHSU -> 10, a=rs1, b=rs2; 011 MULHU -> 11; funct3[2] is ignored.
REQ-015 SHALL select the result as mul_p[31:0] for funct3 000 and mul_p[63:32] otherwise.
REQ-016 SHALL, in BUSY with mul_done=1 and out_valid=0, capture the result, rob_idx and pd into the output buffer, set out_valid, and go BUSY->DRAIN.
REQ-017 SHALL, in BUSY with mul_done=1 and out_valid=1 (buffer not granted), keep mul_start=1 and stay in BUSY until out_valid clears.
REQ-018 SHALL hold mul_start=0 in DRAIN for exactly one cycle, then go DRAIN->IDLE, so the multiplier returns to idle before the next start.
REQ-019 SHALL drive cdb_valid=out_valid, with cdb_value/cdb_rob_idx/cdb_pd stable while cdb_valid=1 and cdb_grant=0.
REQ-020 SHALL clear out_valid on the edge where cdb_valid & cdb_grant; cdb_grant with cdb_valid=0 SHALL be ignored.
REQ-021 SHALL permit same-cycle grant and capture: the granted entry leaves and the new result loads, so out_valid stays 1.
REQ-022 SHALL, on flush, clear out_valid and, if in BUSY, mark the in-flight op squashed; a squashed op keeps the BUSY handshake until mul_done, then goes to DRAIN without capturing.
REQ-023 SHALL NOT accept an issue on a flush cycle; flush in IDLE or DRAIN SHALL NOT change state.
REQ-024 SHALL make end-to-end latency (accept to first cdb_valid) equal to multiplier start-to-done cycles plus 2, with no back-pressure.

Reset
REQ-025 SHALL, while rst=1, set state=IDLE, out_valid=0 and squashed=0, and drive mul_start=0, cdb_valid=0 and iss_ready=0.
REQ-026 SHALL, on rst mid-operation, discard the in-flight op with no CDB broadcast; iss_ready=1 on the first cycle after rst deasserts.

Verification
REQ-027 SHALL test: MUL rs1=7, rs2=6, rob 3, pd 9 -> one cdb_valid pulse with value 0x0000002A, rob 3, pd 9; with multiplier done at T+4, cdb_valid first at T+5.
REQ-028 SHALL test: MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MUL same operands -> 0x00000001.
REQ-029 SHALL test: MULHSU rs1=0xFFFFFFFE, rs2=3 -> 0xFFFFFFFF; MUL rs1=0, rs2=5 -> 0x00000000 via the multiplier's early-done path.
REQ-030 SHALL test: cdb_grant held 0 for 12 cycles over two back-to-back MULs (5*5, 6*6) -> first 0x19 stable; second held in BUSY with mul_start=1; after grants, 0x24 follows; no loss or reordering.
REQ-031 SHALL test: flush in the second BUSY cycle of a MUL 3*3 -> no cdb_valid for it; iss_ready returns after DRAIN; next MUL 2*2 -> 0x4.
REQ-032 SHALL test: rst asserted mid-BUSY, then MUL 9*9 -> exactly one broadcast, value 0x51.
